// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
// The PARITY state is only reachable when FIFO_UART_TX_PARITY_EN is defined.
package uart_tx_pkg;

   localparam int DATA_W    = 8;
   localparam int BIT_IDX_W = $clog2(DATA_W);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_e;

   // Clock cycles from the first start-bit cycle to the last stop-bit cycle.
   function automatic int frame_len(input int clk_div, input int stop_bits, input int parity_bits);
      return (1 + DATA_W + parity_bits + stop_bits) * clk_div;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLK_DIV-1 and strobes bit_end on the final count.
// bit_pre_end fires one cycle earlier so callers can register an end-of-bit output.
module uart_baud_gen #(
   parameter int CLK_DIV = 16
) (
   input  logic clk_in,
   input  logic rst_n,
   input  logic clr,
   output logic bit_end,
   output logic bit_pre_end
);

   localparam int CNT_W = $clog2(CLK_DIV);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clr || bit_end)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   assign bit_end     = (cnt == CNT_W'(CLK_DIV - 1));
   assign bit_pre_end = (cnt == CNT_W'(CLK_DIV - 2));

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a show-ahead FIFO and serialises each byte as an LSB-first UART frame.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module fifo_uart_tx
   import uart_tx_pkg::*;
#(
   parameter int CLK_DIV   = 16,
   parameter int STOP_BITS = 1
) (
   input  logic              clk_in,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] fifo_q,
   input  logic              fifo_empty,
   output logic              fifo_rdreq,
   input  logic              enable,
   output logic              tx,
   output logic              busy,
   output logic              frame_done
);

   tx_state_e            state, state_nxt;
   logic                 bit_end, bit_pre_end, baud_clr;
   logic                 launch, last_stop, pop;
   logic [BIT_IDX_W-1:0] bit_idx;
   logic [DATA_W-1:0]    shreg, shreg_nxt;
   logic                 stop_idx;
   logic                 tx_nxt, busy_nxt, frame_done_nxt;
`ifdef FIFO_UART_TX_PARITY_EN
   logic                 parity;
`endif

   uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
      .clk_in      (clk_in),
      .rst_n       (rst_n),
      .clr         (baud_clr),
      .bit_end     (bit_end),
      .bit_pre_end (bit_pre_end)
   );

   assign launch    = enable && !fifo_empty;
   assign last_stop = (STOP_BITS == 1) || stop_idx;
   // rst_n gates the pop so a held reset never drains the FIFO.
   assign pop       = rst_n && launch &&
                      ((state == IDLE) || ((state == STOP) && last_stop && bit_end));
   assign fifo_rdreq = pop;
   assign baud_clr   = (state == IDLE) || (state_nxt != state);

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:   if (pop) state_nxt = START;
         START:  if (bit_end) state_nxt = DATA;
`ifdef FIFO_UART_TX_PARITY_EN
         DATA:   if (bit_end && (bit_idx == BIT_IDX_W'(DATA_W - 1))) state_nxt = PARITY;
         PARITY: if (bit_end) state_nxt = STOP;
`else
         DATA:   if (bit_end && (bit_idx == BIT_IDX_W'(DATA_W - 1))) state_nxt = STOP;
`endif
         STOP:   if (bit_end && last_stop) state_nxt = pop ? START : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Line level is computed from the next state so tx changes on the entry edge.
   always_comb begin
      shreg_nxt = shreg;
      if (pop)
         shreg_nxt = fifo_q;
      else if ((state == DATA) && bit_end)
         shreg_nxt = shreg >> 1;
      case (state_nxt)
         START:   tx_nxt = 1'b0;
         DATA:    tx_nxt = shreg_nxt[0];
`ifdef FIFO_UART_TX_PARITY_EN
         PARITY:  tx_nxt = parity;
`endif
         default: tx_nxt = 1'b1;
      endcase
      busy_nxt       = (state_nxt != IDLE);
      frame_done_nxt = (state == STOP) && last_stop && bit_pre_end;
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         tx         <= 1'b1;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         shreg      <= '0;
         bit_idx    <= '0;
         stop_idx   <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
         parity     <= 1'b0;
`endif
      end else begin
         tx         <= tx_nxt;
         busy       <= busy_nxt;
         frame_done <= frame_done_nxt;
         shreg      <= shreg_nxt;
         if (pop)
            bit_idx <= '0;
         else if ((state == DATA) && bit_end)
            bit_idx <= bit_idx + 1'b1;
         if (state != STOP)
            stop_idx <= 1'b0;
         else if (bit_end)
            stop_idx <= ~stop_idx;
`ifdef FIFO_UART_TX_PARITY_EN
         if (pop)
            parity <= ^fifo_q;
`endif
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx (CLK_DIV=4, STOP_BITS=1); pops queue expected
// frames, an independent monitor checks every line cycle against hand-written vectors.
module tb_fifo_uart_tx;

   localparam int CLK_DIV = 4;
`ifdef FIFO_UART_TX_PARITY_EN
   localparam int F = 44;
`else
   localparam int F = 40;
`endif
   localparam int NB = F / CLK_DIV;

   typedef struct {
      logic [7:0] data;
      int         pcyc;
   } exp_t;

   logic       clk_in;
   logic       rst_n;
   logic [7:0] fifo_q;
   logic       fifo_empty;
   logic       fifo_rdreq;
   logic       enable;
   logic       tx;
   logic       busy;
   logic       frame_done;

   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   int         rd_cnt = 0;
   int         last_pop = -1;
   int         fd_total = 0;
   logic [7:0] fq[$];
   exp_t       exp_q[$];
   int         pops[$];
   int         fd_cyc[$];

   fifo_uart_tx #(.CLK_DIV(CLK_DIV), .STOP_BITS(1)) dut (
      .clk_in     (clk_in),
      .rst_n      (rst_n),
      .fifo_q     (fifo_q),
      .fifo_empty (fifo_empty),
      .fifo_rdreq (fifo_rdreq),
      .enable     (enable),
      .tx         (tx),
      .busy       (busy),
      .frame_done (frame_done)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;

   // Bit k of each vector is the line level during bit period k (start first).
   function automatic logic [10:0] exp_line(input logic [7:0] b);
`ifdef FIFO_UART_TX_PARITY_EN
      case (b)
         8'hA5:   return 11'b1_0_10100101_0;
         8'h00:   return 11'b1_0_00000000_0;
         8'hFF:   return 11'b1_0_11111111_0;
         8'h07:   return 11'b1_1_00000111_0;
         8'h3C:   return 11'b1_0_00111100_0;
         8'h5A:   return 11'b1_0_01011010_0;
         8'h81:   return 11'b1_0_10000001_0;
         8'h01:   return 11'b1_1_00000001_0;
         default: return 11'h7FF;
      endcase
`else
      case (b)
         8'hA5:   return 11'b0_1_10100101_0;
         8'h00:   return 11'b0_1_00000000_0;
         8'hFF:   return 11'b0_1_11111111_0;
         8'h07:   return 11'b0_1_00000111_0;
         8'h3C:   return 11'b0_1_00111100_0;
         8'h5A:   return 11'b0_1_01011010_0;
         8'h81:   return 11'b0_1_10000001_0;
         8'h01:   return 11'b0_1_00000001_0;
         default: return 11'h7FF;
      endcase
`endif
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic fifo_refresh();
      fifo_empty = (fq.size() == 0);
      fifo_q     = (fq.size() != 0) ? fq[0] : 8'h00;
   endtask

   task automatic fifo_push(input logic [7:0] b);
      fq.push_back(b);
      fifo_refresh();
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic goto_cyc(input int c);
      do tick(); while (cyc < c);
   endtask

   task automatic wait_pops(input int n, input string what);
      int t;
      t = 0;
      while (rd_cnt < n && t < 300) begin
         @(negedge clk_in);
         t++;
      end
      chk({what, " pop count"}, rd_cnt, n);
   endtask

   task automatic wait_idle(input string what);
      int t;
      t = 0;
      while ((exp_q.size() != 0 || busy !== 1'b0) && t < 400) begin
         @(negedge clk_in);
         t++;
      end
      #1;
      chk({what, " drained"}, int'(exp_q.size() == 0 && busy === 1'b0), 1);
   endtask

   // FIFO model: serves the head word and records every pop as an expected frame.
   initial begin : fifo_model
      forever begin
         @(negedge clk_in);
         if (fifo_rdreq === 1'b1) begin
            chk("rdreq while empty", int'(fifo_empty), 0);
            rd_cnt++;
            last_pop = cyc;
            pops.push_back(cyc);
            exp_q.push_back('{data: fifo_q, pcyc: cyc});
            @(posedge clk_in);
            #1;
            if (fq.size() != 0) void'(fq.pop_front());
            fifo_refresh();
         end
      end
   end

   always @(negedge clk_in) begin
      if (frame_done === 1'b1) begin
         fd_total++;
         fd_cyc.push_back(cyc);
      end
   end

   // Monitor: walks the F line cycles following each pop.
   initial begin : monitor
      exp_t       e;
      logic [10:0] vec;
      int         ones [11];
      int         busy_hi, fd_hits, fd_at;
      bit         aborted;
      forever begin
         @(negedge clk_in);
         if (exp_q.size() > 0 && cyc == exp_q[0].pcyc + 1) begin
            e = exp_q[0];
            vec = exp_line(e.data);
            foreach (ones[i]) ones[i] = 0;
            busy_hi = 0; fd_hits = 0; fd_at = -1; aborted = 0;
            for (int k = 0; k < F; k++) begin
               if (k > 0) @(negedge clk_in);
               if (!rst_n) begin
                  aborted = 1;
                  break;
               end
               if (tx === 1'b1) ones[k / CLK_DIV]++;
               if (busy === 1'b1) busy_hi++;
               if (frame_done === 1'b1) begin
                  fd_hits++;
                  fd_at = k;
               end
            end
            void'(exp_q.pop_front());
            if (!aborted) begin
               for (int b = 0; b < NB; b++)
                  chk($sformatf("frame %02h bit%0d high-cycles", e.data, b), ones[b],
                      vec[b] ? CLK_DIV : 0);
               chk($sformatf("frame %02h busy cycles", e.data), busy_hi, F);
               chk($sformatf("frame %02h frame_done pulses", e.data), fd_hits, 1);
               chk($sformatf("frame %02h frame_done offset", e.data), fd_at + 1, F);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "timeout");
   end

   initial begin : stim
      int p, c, r, n0p, n0f, d;
      rst_n  = 1'b1;
      enable = 1'b1;
      fifo_q = 8'h00;
      fifo_empty = 1'b1;
      #1 rst_n = 1'b0;
      fifo_push(8'hA5);

      // 1: reset held with work pending
      repeat (4) begin
         @(negedge clk_in);
         chk("reset {tx,busy,rdreq,done}", int'({tx, busy, fifo_rdreq, frame_done}), 8);
      end

      // 2: single frame straight out of reset
      tick();
      r = cyc;
      rst_n = 1'b1;
      wait_pops(1, "single");
      chk("single pop cycle", last_pop, r);
      wait_idle("single");
      repeat (3) @(negedge clk_in);
      chk("single rdreq total", rd_cnt, 1);
      chk("idle tx", int'(tx), 1);

      // 3: back-to-back frames
      n0p = pops.size();
      n0f = fd_cyc.size();
      tick();
      fifo_push(8'h00);
      fifo_push(8'hFF);
      wait_pops(3, "b2b");
      wait_idle("b2b");
      d = (pops.size() >= n0p + 2) ? pops[n0p + 1] - pops[n0p] : -1;
      chk("b2b pop spacing", d, F);
      d = (fd_cyc.size() >= n0f + 2) ? fd_cyc[n0f + 1] - fd_cyc[n0f] : -1;
      chk("b2b frame_done spacing", d, F);

      // 4: byte with odd popcount (parity bit 1 when compiled in)
      tick();
      fifo_push(8'h07);
      wait_pops(4, "byte07");
      wait_idle("byte07");

      // 5: enable dropped during data bit 3
      tick();
      fifo_push(8'h3C);
      fifo_push(8'h5A);
      wait_pops(5, "enable");
      p = last_pop;
      goto_cyc(p + 18);
      enable = 1'b0;
      wait_idle("enable");
      repeat (10) @(negedge clk_in);
      chk("no pop while disabled", rd_cnt, 5);
      chk("disabled busy", int'(busy), 0);
      tick();
      c = cyc;
      enable = 1'b1;
      @(negedge clk_in);
      chk("rdreq on re-enable", int'(fifo_rdreq), 1);
      wait_pops(6, "re-enable");
      chk("re-enable pop cycle", last_pop, c);
      wait_idle("re-enable");

      // 6: reset during data bit 5
      tick();
      fifo_push(8'h81);
      fifo_push(8'h01);
      wait_pops(7, "reset");
      p = last_pop;
      goto_cyc(p + 26);
      rst_n = 1'b0;
      #1;
      chk("async reset tx", int'(tx), 1);
      chk("async reset busy", int'(busy), 0);
      chk("async reset rdreq", int'(fifo_rdreq), 0);
      repeat (3) tick();
      r = cyc;
      rst_n = 1'b1;
      wait_pops(8, "post-reset");
      chk("post-reset pop cycle", last_pop, r);
      wait_idle("post-reset");

      repeat (5) @(negedge clk_in);
      chk("scoreboard empty", exp_q.size(), 0);
      chk("frame_done total", fd_total, 7);
      chk("rdreq total", rd_cnt, 8);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
